matmul_result_stream: RTL and testbench

//   Downstream drain stage for the matmul core. On the core's one-cycle done

---
 rtl/matmul_pkg.sv | 10 +
 rtl/matmul_result_stream.sv | 104 ++++++++++
 tb/tb_matmul_result_stream.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul core and its drain/egress stages.
package matmul_pkg;

  // Default accumulator / output word width.
  localparam int ACC_W_DEF = 32;

  // Drain stage FSM: waiting for a finished matrix, or emitting one.
  typedef enum logic {S_IDLE, S_STREAM} drain_state_t;

endpackage

// File: rtl/matmul_result_stream.sv
// Result drain stage. On the core's done pulse, snapshot the M x N accumulator
// matrix, then emit it row-major on a valid/ready stream, one word per beat,
// with out_last on the final element. A done coincident with the final
// transfer is accepted back-to-back. Any other done while streaming is
// dropped and latched in the sticky overrun flag.
module matmul_result_stream
  import matmul_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int M     = 2,
  parameter int N     = 2
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    done,
  input  logic signed [M-1:0][N-1:0][ACC_W-1:0]   C,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic signed [ACC_W-1:0]                 out_data,
  output logic                                    out_last,
  output logic                                    busy,
  output logic                                    overrun
);

  localparam int                ELEMS = M * N;
  localparam int                IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(ELEMS - 1);

  drain_state_t                       state;
  logic [IDX_W-1:0]                   idx;
  // Flattened row-major: element r*N+c matches the packed layout of C.
  logic [ELEMS-1:0][ACC_W-1:0]        snap;

  logic xfer;
  logic xfer_last;
  assign xfer      = out_valid && out_ready;
  assign xfer_last = xfer && (idx == LAST);

  // Outputs come only from state/idx/snap registers, never from C or done.
  assign out_valid = (state == S_STREAM);
  assign busy      = (state == S_STREAM);
  assign out_last  = (state == S_STREAM) && (idx == LAST);
  assign out_data  = snap[idx];

  // FSM, element index and snapshot capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      snap  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (done) begin
            snap  <= C;
            idx   <= '0;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (xfer_last) begin
            idx <= '0;
            if (done) snap  <= C;      // back-to-back: stay streaming
            else      state <= S_IDLE;
          end else if (xfer) begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky flag: a done that could not be accepted was dropped.
  always_ff @(posedge clk) begin
    if (!rst_n)                                       overrun <= 1'b0;
    else if (done && state == S_STREAM && !xfer_last) overrun <= 1'b1;
  end

`ifndef SYNTHESIS
  logic                    stall_q;
  logic [ACC_W-1:0]        data_q;
  logic                    last_q;

  // Remember the beat presented during a stall so the next cycle can compare.
  always_ff @(posedge clk) begin
    stall_q <= rst_n && out_valid && !out_ready;
    data_q  <= out_data;
    last_q  <= out_last;
  end

  // Stream protocol invariants.
  always_ff @(posedge clk) begin
    if (rst_n && stall_q)
      assert (out_data == data_q && out_last == last_q)
        else $error("stalled beat changed");
    if (rst_n) begin
      assert (!out_last || out_valid) else $error("out_last without out_valid");
      assert (busy || !out_valid)     else $error("out_valid while not busy");
    end
  end
`endif

endmodule

// File: tb/tb_matmul_result_stream.sv
// Directed bench for matmul_result_stream with hand-computed expected beats.
module tb_matmul_result_stream;

  logic                        clk;
  logic                        rst_n;
  logic                        done;
  logic signed [1:0][1:0][31:0] C;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [31:0]          out_data;
  logic                        out_last;
  logic                        busy;
  logic                        overrun;

  int errors = 0;
  int checks = 0;

  matmul_result_stream #(.ACC_W(32), .M(2), .N(2)) dut (
    .clk(clk), .rst_n(rst_n), .done(done), .C(C),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic set_base();
    C[0][0] = 32'd1;  C[0][1] = -32'sd2;
    C[1][0] = 32'd3;  C[1][1] = 32'h7FFF_FFFF;
  endtask

  task automatic set_second();
    C[0][0] = 32'd5;  C[0][1] = 32'd6;
    C[1][0] = 32'd7;  C[1][1] = 32'd8;
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] d, input logic l);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_last"},  {31'd0, out_last}, {31'd0, l});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_last"},  {31'd0, out_last}, 32'd0);
  endtask

  logic [31:0] base [4];
  int          pat  [7];
  int          beat;

  initial begin
    base = '{32'd1, 32'hFFFF_FFFE, 32'd3, 32'h7FFF_FFFF};
    pat  = '{1, 0, 0, 1, 0, 1, 1};
    rst_n = 1'b0; done = 1'b0; out_ready = 1'b0; C = '0;
    step(); step();
    rst_n = 1'b1;

    // T1: reset in the middle of a stalled stream that also overran.
    set_base(); done = 1'b1;
    step();
    chk("t1_pre_valid", {31'd0, out_valid}, 32'd1);
    step();                                   // second done while streaming
    done = 1'b0;
    chk("t1_pre_overrun", {31'd0, overrun}, 32'd1);
    rst_n = 1'b0;
    step();
    chk_idle("t1_rst");
    chk("t1_rst_data", out_data, 32'd0);
    chk("t1_rst_overrun", {31'd0, overrun}, 32'd0);
    step();
    rst_n = 1'b1;

    // T2: full-rate stream, latency 1 from done.
    set_base(); out_ready = 1'b1; done = 1'b1;
    step();
    done = 1'b0;
    chk_beat("t2_b0", 32'd1, 1'b0);          step();
    chk_beat("t2_b1", 32'hFFFF_FFFE, 1'b0);  step();
    chk_beat("t2_b2", 32'd3, 1'b0);          step();
    chk_beat("t2_b3", 32'h7FFF_FFFF, 1'b1);  step();
    chk_idle("t2_end");

    // T3: backpressure, each word exactly once and held across stalls.
    out_ready = 1'b0; done = 1'b1;
    step();
    done = 1'b0;
    beat = 0;
    for (int k = 0; k < 7; k++) begin
      out_ready = pat[k][0];
      chk_beat($sformatf("t3_c%0d", k), base[beat], beat == 3);
      step();
      if (pat[k] != 0) beat++;
    end
    chk("t3_count", beat, 32'd4);
    chk_idle("t3_end");

    // T4: done mid-stream is dropped and flagged.
    out_ready = 1'b1; done = 1'b1;
    step();
    done = 1'b0;
    chk_beat("t4_b0", 32'd1, 1'b0);  step();
    chk_beat("t4_b1", 32'hFFFF_FFFE, 1'b0);
    C = '{'{32'd9, 32'd9}, '{32'd9, 32'd9}}; done = 1'b1;
    step();
    done = 1'b0;
    chk_beat("t4_b2", 32'd3, 1'b0);
    chk("t4_ovr_a", {31'd0, overrun}, 32'd1);  step();
    chk_beat("t4_b3", 32'h7FFF_FFFF, 1'b1);    step();
    chk_idle("t4_end");
    chk("t4_ovr_b", {31'd0, overrun}, 32'd1);
    step();
    chk("t4_ovr_c", {31'd0, overrun}, 32'd1);

    // T5: back-to-back on the final transfer, no bubble, no overrun.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    set_base(); done = 1'b1;
    step();
    done = 1'b0;
    chk_beat("t5_a0", 32'd1, 1'b0);          step();
    chk_beat("t5_a1", 32'hFFFF_FFFE, 1'b0);  step();
    chk_beat("t5_a2", 32'd3, 1'b0);          step();
    chk_beat("t5_a3", 32'h7FFF_FFFF, 1'b1);
    set_second(); done = 1'b1;
    step();
    done = 1'b0;
    chk_beat("t5_b0", 32'd5, 1'b0);  step();
    chk_beat("t5_b1", 32'd6, 1'b0);  step();
    chk_beat("t5_b2", 32'd7, 1'b0);  step();
    chk_beat("t5_b3", 32'd8, 1'b1);  step();
    chk_idle("t5_end");
    chk("t5_ovr", {31'd0, overrun}, 32'd0);

    // T6: reset after beat 2 aborts, next done restarts at idx 0.
    set_base(); done = 1'b1;
    step();
    done = 1'b0;
    chk_beat("t6_a0", 32'd1, 1'b0);  step();
    chk_beat("t6_a1", 32'hFFFF_FFFE, 1'b0);
    rst_n = 1'b0;
    step();
    chk_idle("t6_rst");
    rst_n = 1'b1;
    step();
    chk_idle("t6_quiet");
    set_second(); done = 1'b1;
    step();
    done = 1'b0;
    chk_beat("t6_b0", 32'd5, 1'b0);  step();
    chk_beat("t6_b1", 32'd6, 1'b0);  step();
    chk_beat("t6_b2", 32'd7, 1'b0);  step();
    chk_beat("t6_b3", 32'd8, 1'b1);  step();
    chk_idle("t6_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
